// File: rtl/sipo.sv
// Oversampling serial receiver: 8 data bits, LSB first, one parity bit, one stop bit.
// rx is synchronised with two flops; bit timing is taken from the start-bit falling edge only.
module sipo #(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       bd_clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       data_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       active
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [5:0] MID_C  = 6'(OVERSAMPLE / 2 - 1);
   localparam logic [5:0] LAST_C = 6'(OVERSAMPLE - 1);

   function automatic logic expected_parity(input logic [7:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   logic       rx_meta_r;
   logic       rxs_r;
   logic [1:0] warm_r;
   logic       armed_r;
   state_t     state_r;
   logic [5:0] cnt_r;
   logic [2:0] bit_idx_r;
   logic [7:0] shift_r;
   logic       par_bit_r;
   logic       stop_bit_r;
   logic       done_r;

   // Two-flop synchroniser for the asynchronous serial line.
   always_ff @(posedge bd_clk) begin
      if (!rst_n) begin
         rx_meta_r <= 1'b1;
         rxs_r     <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rxs_r     <= rx_meta_r;
      end
   end

   // Start detection stays disarmed until a genuine high has passed through the synchroniser,
   // so a start bit already in progress during reset is ignored.
   always_ff @(posedge bd_clk) begin
      if (!rst_n) begin
         warm_r  <= 2'd0;
         armed_r <= 1'b0;
      end else begin
         if (warm_r != 2'd2) begin
            warm_r <= warm_r + 2'd1;
         end
         if ((warm_r == 2'd2) && rxs_r) begin
            armed_r <= 1'b1;
         end
      end
   end

   // Frame FSM with registered outputs; frame-done actions land one edge after the stop sample.
   always_ff @(posedge bd_clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 6'd0;
         bit_idx_r   <= 3'd0;
         shift_r     <= 8'hFF;
         par_bit_r   <= 1'b0;
         stop_bit_r  <= 1'b0;
         done_r      <= 1'b0;
         data_out    <= 8'h00;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         active      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (armed_r && !rxs_r) begin
                  state_r <= ST_START;
                  cnt_r   <= 6'd0;
                  active  <= 1'b1;
               end
            end
            ST_START: begin
               if (cnt_r == MID_C) begin
                  cnt_r <= 6'd0;
                  if (rxs_r) begin
                     state_r <= ST_IDLE;
                     active  <= 1'b0;
                  end else begin
                     state_r   <= ST_DATA;
                     bit_idx_r <= 3'd0;
                  end
               end else begin
                  cnt_r <= cnt_r + 6'd1;
               end
            end
            ST_DATA: begin
               if (cnt_r == LAST_C) begin
                  cnt_r     <= 6'd0;
                  shift_r   <= {rxs_r, shift_r[7:1]};
                  bit_idx_r <= bit_idx_r + 3'd1;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= ST_PARITY;
                  end
               end else begin
                  cnt_r <= cnt_r + 6'd1;
               end
            end
            ST_PARITY: begin
               if (cnt_r == LAST_C) begin
                  cnt_r     <= 6'd0;
                  par_bit_r <= rxs_r;
                  state_r   <= ST_STOP;
               end else begin
                  cnt_r <= cnt_r + 6'd1;
               end
            end
            ST_STOP: begin
               if (cnt_r == LAST_C) begin
                  cnt_r      <= 6'd0;
                  stop_bit_r <= rxs_r;
                  done_r     <= 1'b1;
                  state_r    <= ST_IDLE;
                  active     <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 6'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 6'd0;
               active  <= 1'b0;
            end
         endcase

         // A completing frame takes priority over a simultaneous acknowledge.
         if (done_r) begin
            data_out    <= shift_r;
            parity_err  <= (par_bit_r != expected_parity(shift_r, PARITY_ODD));
            frame_err   <= ~stop_bit_r;
            data_valid  <= 1'b1;
            overrun_err <= data_valid & ~data_ack;
         end else if (data_ack && data_valid) begin
            data_valid  <= 1'b0;
            overrun_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo: one even-parity and one odd-parity instance share the same line.
module tb_sipo;

   localparam int OS  = 16;
   localparam int LAT = 4 + OS / 2 + 10 * OS;

   logic       bd_clk   = 1'b0;
   logic       rst_n    = 1'b0;
   logic       rx       = 1'b1;
   logic       data_ack = 1'b0;

   logic [7:0] e_data_out, o_data_out;
   logic       e_valid, e_perr, e_ferr, e_ovr, e_active;
   logic       o_valid, o_perr, o_ferr, o_ovr, o_active;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int         due;
      logic [7:0] d;
      logic       perr_e;
      logic       perr_o;
      logic       ferr;
      logic       prev_valid;
      logic       ovr;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   sipo #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) u_even (
      .bd_clk(bd_clk), .rst_n(rst_n), .rx(rx), .data_ack(data_ack),
      .data_out(e_data_out), .data_valid(e_valid), .parity_err(e_perr),
      .frame_err(e_ferr), .overrun_err(e_ovr), .active(e_active)
   );

   sipo #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) u_odd (
      .bd_clk(bd_clk), .rst_n(rst_n), .rx(rx), .data_ack(data_ack),
      .data_out(o_data_out), .data_valid(o_valid), .parity_err(o_perr),
      .frame_err(o_ferr), .overrun_err(o_ovr), .active(o_active)
   );

   always #5 bd_clk = ~bd_clk;

   always @(posedge bd_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge bd_clk);
         #1;
      end
   endtask

   task automatic check_outs(input string tag, input logic [7:0] d, input logic v, input logic p,
                             input logic f, input logic o, input logic a);
      check_eq({tag, "_even_data"}, 32'(e_data_out), 32'(d));
      check_eq({tag, "_even_valid"}, 32'(e_valid), 32'(v));
      check_eq({tag, "_even_perr"}, 32'(e_perr), 32'(p));
      check_eq({tag, "_even_ferr"}, 32'(e_ferr), 32'(f));
      check_eq({tag, "_even_ovr"}, 32'(e_ovr), 32'(o));
      check_eq({tag, "_even_active"}, 32'(e_active), 32'(a));
      check_eq({tag, "_odd_data"}, 32'(o_data_out), 32'(d));
      check_eq({tag, "_odd_valid"}, 32'(o_valid), 32'(v));
      check_eq({tag, "_odd_active"}, 32'(o_active), 32'(a));
   endtask

   // Scoreboard: verify data_valid the cycle before completion, then every result field on it.
   always @(negedge bd_clk) begin
      if (sb_q.size() != 0) begin
         if (cyc == sb_q[0].due - 1) begin
            check_eq("pre_done_valid", 32'(e_valid), 32'(sb_q[0].prev_valid));
         end else if (cyc == sb_q[0].due) begin
            sb_e = sb_q.pop_front();
            check_eq("done_data_even", 32'(e_data_out), 32'(sb_e.d));
            check_eq("done_data_odd", 32'(o_data_out), 32'(sb_e.d));
            check_eq("done_valid_even", 32'(e_valid), 32'd1);
            check_eq("done_valid_odd", 32'(o_valid), 32'd1);
            check_eq("done_perr_even", 32'(e_perr), 32'(sb_e.perr_e));
            check_eq("done_perr_odd", 32'(o_perr), 32'(sb_e.perr_o));
            check_eq("done_ferr", 32'(e_ferr), 32'(sb_e.ferr));
            check_eq("done_ovr", 32'(e_ovr), 32'(sb_e.ovr));
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input logic prev_valid, input logic ovr, input logic want_out);
      logic [10:0] bits;
      exp_t        e;
      bits = {stop, par, d, 1'b0};
      if (want_out) begin
         e.due        = cyc + LAT;
         e.d          = d;
         e.perr_e     = (par != ^d);
         e.perr_o     = (par != ~^d);
         e.ferr       = ~stop;
         e.prev_valid = prev_valid;
         e.ovr        = ovr;
         sb_q.push_back(e);
      end
      for (int i = 0; i < 11; i++) begin
         rx = bits[i];
         tick(OS);
      end
      rx = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < LAT + OS && sb_q.size() != 0; i++) tick(1);
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic ack_clear(input logic [7:0] d, input logic perr_e, input logic ferr);
      data_ack = 1'b1;
      tick(1);
      data_ack = 1'b0;
      check_eq("ack_valid", 32'(e_valid), 32'd0);
      check_eq("ack_ovr", 32'(e_ovr), 32'd0);
      check_eq("ack_data_hold", 32'(e_data_out), 32'(d));
      check_eq("ack_perr_hold", 32'(e_perr), 32'(perr_e));
      check_eq("ack_ferr_hold", 32'(e_ferr), 32'(ferr));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0;
      rst_n = 1'b0;
      rx    = 1'b1;
      tick(3);
      check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(8);

      // 0xA5 with correct even parity, then with the parity bit flipped
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();
      ack_clear(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();
      ack_clear(8'hA5, 1'b1, 1'b0);
      tick(4);

      // false start: line low for 4 clocks
      c0 = cyc;
      rx = 1'b0;
      tick(3);
      check_eq("fs_active_rise", 32'(e_active), 32'd1);
      tick(1);
      rx = 1'b1;
      tick(OS / 2 - 2);
      check_eq("fs_active_hold", 32'(e_active), 32'd1);
      tick(1);
      check_eq("fs_active_fall", 32'(e_active), 32'd0);
      check_eq("fs_cycle", 32'(cyc - c0), 32'(3 + OS / 2));
      check_eq("fs_no_valid", 32'(e_valid), 32'd0);
      tick(OS);

      // stop bit sampled low
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();
      tick(2 * OS);
      check_eq("ferr_active_idle", 32'(e_active), 32'd0);
      ack_clear(8'h3C, 1'b0, 1'b1);
      tick(4);

      // back-to-back frames without acknowledge
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      drain();
      ack_clear(8'h22, 1'b0, 1'b0);
      tick(4);

      // acknowledge landing on the same edge as frame-done
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();
      fork
         send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
         begin
            tick(LAT - 1);
            data_ack = 1'b1;
            tick(1);
            data_ack = 1'b0;
         end
      join
      drain();
      check_eq("same_edge_valid", 32'(e_valid), 32'd1);
      tick(4);

      // reset pulse in the middle of data bit 4
      fork
         send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         begin
            tick(5 * OS + OS / 2);
            check_eq("pre_rst_active", 32'(e_active), 32'd1);
            rst_n = 1'b0;
            tick(1);
            check_outs("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            rst_n = 1'b1;
         end
      join
      tick(8 * OS);
      check_eq("post_rst_no_valid_even", 32'(e_valid), 32'd0);
      check_eq("post_rst_no_valid_odd", 32'(o_valid), 32'd0);
      check_eq("post_rst_active", 32'(e_active), 32'd0);

      // receiver recovers after reset
      send_frame(8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
